i2s_tx: RTL and testbench
=========================

# i2s_tx

Serialises left/right sample pairs into the team's I2S-style bit stream (out_valid, WS, SD), MSB first, one bit per clk. It is the transmit end of the link whose receive end rebuilds 32-bit left/right words from in_valid/WS/SD. Upstream hands over one sample pair per frame through a valid/ready handshake. A one-entry holding buffer lets frames go out back-to-back with no idle cycle.

## Interface
- DATA_W, 32: bits per channel word. The only required value is 32, to match the receiver.
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream offers a sample pair
- in_left  input  DATA_W  left word, sampled on accept
- in_right  input  DATA_W  right word, sampled on accept
- in_ready  output  1  holding buffer empty; accept = in_valid & in_ready at a rising edge
- out_valid  output  1  SD/WS carry a valid bit this cycle (drives the receiver's in_valid)
- WS  output  1  word select: 0 = left-channel bit, 1 = right-channel bit
- SD  output  1  serial data, MSB first

## Operation
- Storage:
  - Holding buffer: buf_l, buf_r, buf_full.
  - Transmit shifter: 2*DATA_W bits.
  - Bit counter: clog2(DATA_W) bits.
  - State: IDLE, TXL, TXR.
- in_ready = ~buf_full, driven directly from the flop. An accept sets buf_full and captures in_left/in_right.
- State transitions:
  - IDLE: if buf_full, load the shifter with {buf_l, buf_r}, clear buf_full, clear the counter, go to TXL. Otherwise stay in IDLE.
  - TXL: send one left bit per cycle. After bit DATA_W-1, go to TXR and clear the counter.
  - TXR: send one right bit per cycle. After bit DATA_W-1:
    - if buf_full: load the shifter from the buffer, clear buf_full, go to TXL. No gap between frames.
    - else: go to IDLE.
- Registered outputs:
  - In TXL/TXR: out_valid=1, WS=0 in TXL and 1 in TXR, SD = shifter MSB. The shifter shifts left each cycle.
  - In IDLE: out_valid=0, WS=0, SD=0.
- Stream alignment: WS and SD are aligned, with no one-bit I2S delay. The first bit with WS=0 is left[DATA_W-1]. The first bit with WS=1 is right[DATA_W-1].
- Simultaneous accept and buffer drain in the same cycle cannot happen, because in_ready is low while buf_full=1. The buffer refills at the earliest on the cycle after a drain.
- Upstream changes to in_left/in_right while in_ready=0 are ignored.

## Timing
- Reset: state=IDLE, buf_full=0 (in_ready=1), out_valid=0, WS=0, SD=0, counter=0. Shifter/buffer data contents are don't-care.
- Reset mid-frame: aborts the frame and discards the buffered pair. On the cycle after rst_n is seen low, out_valid=0.
- Latency: accept at edge t → buf_full after t → first bit (out_valid=1, WS=0, SD=left MSB) after edge t+1.
- Frame length: 2*DATA_W cycles, i.e. 64 with out_valid=1 (32 with WS=0, then 32 with WS=1).
- in_ready rises the cycle after the buffer drains (the frame-start cycle). Upstream then has 2*DATA_W-1 cycles to refill and keep the stream gapless.
- Underrun: if the buffer is empty at the end of the right word, the cycle after the last right bit shows out_valid=0, WS=0. The receiver closes the right word on the in_valid drop.
- Gapless case: the cycle after the last right bit shows WS=0 and the next left MSB. The receiver closes the right word on the WS edge.
- in_valid held high with in_ready low: no state change. The data is held for the next accept.

## Test plan
- Single pair left=32'hA5A5_0F0F, right=32'h1234_5678 from reset:
  - accept at edge 0; out_valid=1 from edge 1 to edge 64;
  - SD bits with WS=0 reassemble to A5A50F0F, bits with WS=1 to 12345678;
  - out_valid=0 at edge 65; in_ready=1 again after edge 1.
- Back-to-back pairs (8000_0001/7FFF_FFFE), then (FFFF_FFFF/0000_0000), second offered as soon as in_ready is high:
  - 128 consecutive cycles with out_valid=1;
  - WS pattern 0×32, 1×32, 0×32, 1×32;
  - a receiver model reports both pairs correctly.
- Late refill: second pair offered 10 cycles after the first frame ends → one or more IDLE cycles with out_valid=0, WS=0, SD=0, then the second frame starts 2 cycles after its accept.
- Reset at bit 40 of a frame with a pair buffered:
  - out_valid=0 and in_ready=1 the cycle after reset;
  - no further bits are sent;
  - a new accept restarts cleanly from the left MSB.
- Backpressure: in_valid held high continuously with new data each cycle → only values present on accept edges (in_ready=1) appear on SD, and no frame is corrupted.
- Loopback: random pairs through i2s_tx into the receiver → every out_left/out_right equals the stimulus, in order.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S-style transmitter: serialises left/right word pairs MSB first, one bit per clk.
// A one-entry holding buffer lets consecutive frames go out with no idle cycle.
module i2s_tx #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              out_valid,
  output logic              WS,
  output logic              SD
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, TXL, TXR} state_e;

  state_e                state_q, state_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_W-1:0]     buf_l_q, buf_l_d;
  logic [DATA_W-1:0]     buf_r_q, buf_r_d;
  logic [2*DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic                  load;
  logic                  accept;

  assign in_ready  = ~buf_full_q;
  assign out_valid = out_valid_q;
  assign WS        = ws_q;
  assign SD        = sd_q;

  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    load        = 1'b0;
    accept      = in_valid & ~buf_full_q;

    // Output flops hold the bit currently on the wire; the shifter holds the bits still to come.
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        ws_d        = 1'b0;
        sd_d        = 1'b0;
        if (buf_full_q) load = 1'b1;
      end
      TXL: begin
        out_valid_d = 1'b1;
        sd_d        = shift_q[2*DATA_W-1];
        shift_d     = {shift_q[2*DATA_W-2:0], 1'b0};
        if (cnt_q == LAST_BIT) begin
          state_d = TXR;
          cnt_d   = '0;
          ws_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ws_d  = 1'b0;
        end
      end
      TXR: begin
        if (cnt_q == LAST_BIT) begin
          if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            ws_d        = 1'b0;
            sd_d        = 1'b0;
          end
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          ws_d        = 1'b1;
          sd_d        = shift_q[2*DATA_W-1];
          shift_d     = {shift_q[2*DATA_W-2:0], 1'b0};
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        ws_d        = 1'b0;
        sd_d        = 1'b0;
      end
    endcase

    // The left MSB goes straight to SD on load, so the shifter keeps only the remaining bits.
    if (load) begin
      state_d     = TXL;
      cnt_d       = '0;
      buf_full_d  = 1'b0;
      out_valid_d = 1'b1;
      ws_d        = 1'b0;
      sd_d        = buf_l_q[DATA_W-1];
      shift_d     = {buf_l_q[DATA_W-2:0], buf_r_q, 1'b0};
    end

    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = in_left;
      buf_r_d    = in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_full_q  <= 1'b0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: queue-based stream model, receiver model and targeted literal checks.
module tb_i2s_tx;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_ready;
  logic          out_valid;
  logic          WS;
  logic          SD;

  int tests = 0;
  int fails = 0;

  i2s_tx #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_left(in_left),
    .in_right(in_right), .in_ready(in_ready), .out_valid(out_valid), .WS(WS), .SD(SD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of {ws,sd} bits still to be shown plus a one-pair buffer.
  logic [1:0]    bitq[$];
  logic [63:0]   rxq[$];
  logic          m_full = 1'b0;
  logic [DW-1:0] m_l, m_r;
  logic          m_acc;
  logic          model_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      bitq.delete();
      m_full = 1'b0;
    end else begin
      m_acc = in_valid && !m_full;
      if (bitq.size() > 0) void'(bitq.pop_front());
      if (bitq.size() == 0 && m_full) begin
        for (int i = DW - 1; i >= 0; i--) bitq.push_back({1'b0, m_l[i]});
        for (int i = DW - 1; i >= 0; i--) bitq.push_back({1'b1, m_r[i]});
        rxq.push_back({m_l, m_r});
        m_full = 1'b0;
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_l    = in_left;
        m_r    = in_right;
      end
    end
    model_live = 1'b1;
  end

  // Receiver model and per-cycle compare.
  logic [DW-1:0] rx_l, rx_r, last_l, last_r;
  int            cnt_l = 0, cnt_r = 0, rx_count = 0;
  logic          prev_v = 1'b0, prev_ws = 1'b0;
  int            run = 0, max_run = 0;
  logic [63:0]   exp_pair;

  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", 64'(out_valid), 64'(bitq.size() > 0));
      chk("ws", 64'(WS), 64'((bitq.size() > 0) ? bitq[0][1] : 1'b0));
      chk("sd", 64'(SD), 64'((bitq.size() > 0) ? bitq[0][0] : 1'b0));
      chk("in_ready", 64'(in_ready), 64'(!m_full));
    end
    if (out_valid === 1'b1) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (!rst_n) begin
      cnt_l = 0; cnt_r = 0; prev_v = 1'b0; prev_ws = 1'b0;
      rxq.delete();
    end else begin
      if (prev_v && prev_ws && !(out_valid === 1'b1 && WS === 1'b1)) begin
        chk("rx_left_bits", 64'(cnt_l), 64'(DW));
        chk("rx_right_bits", 64'(cnt_r), 64'(DW));
        if (rxq.size() == 0) begin
          chk("rx_unexpected_word", 64'(1), 64'(0));
        end else begin
          exp_pair = rxq.pop_front();
          chk("rx_pair", {rx_l, rx_r}, exp_pair);
        end
        last_l = rx_l; last_r = rx_r; rx_count++;
        cnt_l = 0; cnt_r = 0;
      end
      if (out_valid === 1'b1) begin
        if (WS === 1'b0) begin rx_l = {rx_l[DW-2:0], SD}; cnt_l++; end
        else begin rx_r = {rx_r[DW-2:0], SD}; cnt_r++; end
      end
      prev_v = (out_valid === 1'b1); prev_ws = (WS === 1'b1);
    end
  end

  // Called at negedge+1; returns at negedge+1 after the accept edge.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int g = 0;
    in_valid = 1'b1; in_left = l; in_right = r;
    while (in_ready !== 1'b1 && g < 500) begin
      @(negedge clk); #1; g++;
    end
    chk("accept_timeout", 64'(g < 500), 64'(1));
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (!(out_valid === 1'b0 && in_ready === 1'b1) && g < 500) begin
      @(negedge clk); g++;
    end
    chk("idle_timeout", 64'(g < 500), 64'(1));
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_ws", 64'(WS), 64'(0));
    chk("reset_sd", 64'(SD), 64'(0));
    #1 rst_n = 1'b1;

    // Single pair: valid for edges 1..64, low at 65.
    @(negedge clk); #1;
    send(32'hA5A5_0F0F, 32'h1234_5678);
    for (int e = 1; e <= 65; e++) begin
      @(negedge clk);
      if (e == 1) begin
        chk("t1_first_valid", 64'(out_valid), 64'(1));
        chk("t1_first_ws", 64'(WS), 64'(0));
        chk("t1_first_sd", 64'(SD), 64'(1));
        chk("t1_ready_after_load", 64'(in_ready), 64'(1));
      end
      if (e == 33) chk("t1_first_right_ws", 64'(WS), 64'(1));
      if (e == 64) chk("t1_last_valid", 64'(out_valid), 64'(1));
      if (e == 65) chk("t1_end_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk); #1;
    chk("t1_left_word", 64'(last_l), 64'(32'hA5A5_0F0F));
    chk("t1_right_word", 64'(last_r), 64'(32'h1234_5678));

    // Back-to-back pairs.
    max_run = 0; base = rx_count;
    send(32'h8000_0001, 32'h7FFF_FFFE);
    send(32'hFFFF_FFFF, 32'h0000_0000);
    wait_idle();
    @(negedge clk); #1;
    chk("t2_run_len", 64'(max_run), 64'(128));
    chk("t2_pairs", 64'(rx_count - base), 64'(2));
    chk("t2_last_left", 64'(last_l), 64'(32'hFFFF_FFFF));
    chk("t2_last_right", 64'(last_r), 64'(32'h0000_0000));

    // Late refill.
    send(32'h0F0F_1111, 32'h2222_3333);
    wait_idle();
    repeat (10) begin @(negedge clk); #1; end
    send(32'h9ABC_DEF0, 32'h0000_0001);
    @(negedge clk);
    chk("t3_restart_valid", 64'(out_valid), 64'(1));
    chk("t3_restart_sd", 64'(SD), 64'(1));
    #1;
    wait_idle();

    // Reset at bit 40 with a pair buffered.
    send(32'h1357_9BDF, 32'h2468_ACE0);
    send(32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (38) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_valid", 64'(out_valid), 64'(0));
    chk("t4_rst_ready", 64'(in_ready), 64'(1));
    #1 rst_n = 1'b1;
    repeat (70) begin @(negedge clk); #1; end
    send(32'h7000_0000, 32'h0000_0007);
    @(negedge clk);
    chk("t4_restart_sd", 64'(SD), 64'(0));
    chk("t4_restart_ws", 64'(WS), 64'(0));
    #1;
    wait_idle();
    @(negedge clk); #1;
    chk("t4_left_word", 64'(last_l), 64'(32'h7000_0000));

    // Backpressure: new data every cycle with in_valid held high.
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'b1; in_left = $urandom; in_right = $urandom;
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Random loopback with random gaps.
    for (int p = 0; p < 20; p++) begin
      send($urandom, $urandom);
      repeat ($urandom_range(0, 80)) begin @(negedge clk); #1; end
    end
    wait_idle();
    @(negedge clk); #1;
    chk("final_rx_drained", 64'(rxq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
